// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage and its
// pending-write scoreboard.
package wb_pkg;

    typedef logic [4:0]  reg_idx_t;
    typedef logic [63:0] data_t;
    typedef logic [1:0]  sb_cnt_t;

    localparam reg_idx_t XZR_IDX  = 5'd31;
    localparam int       NUM_REGS = 32;
    localparam sb_cnt_t  SB_MAX   = 2'd3;

    typedef struct packed {
        logic     valid;
        logic     reg_write;
        reg_idx_t rd;
        data_t    data;
    } mem_wb_t;

    function automatic logic tracked(input reg_idx_t r, input logic v);
        return v && (r != XZR_IDX);
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending-write counters with saturation, sticky error
// and busy lookup. WB_BYPASS_EN masks busy on a same-cycle final retire.
module wb_scoreboard
    import wb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       issue_en,
    input  logic [4:0] issue_rd,
    input  logic       retire_en,
    input  logic [4:0] retire_rd,
    input  logic       squash_en,
    input  logic [4:0] squash_rd,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    output logic       rs1_busy,
    output logic       rs2_busy,
    output logic       sb_error
);

    sb_cnt_t             cnt     [NUM_REGS];
    sb_cnt_t             cnt_nxt [NUM_REGS];
    logic [NUM_REGS-1:0] ovf;
    logic [NUM_REGS-1:0] unf;
    logic signed [3:0]   sum;
    logic                iss;
    logic                ret;
    logic                sqh;
    logic                hit_i;
    logic                hit_r;
    logic                hit_s;

    assign iss = tracked(issue_rd, issue_en);
    assign ret = tracked(retire_rd, retire_en);
    assign sqh = tracked(squash_rd, squash_en);

    always_comb begin
        ovf = '0;
        unf = '0;
        sum = '0;
        hit_i = 1'b0;
        hit_r = 1'b0;
        hit_s = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            hit_i = iss && (issue_rd == reg_idx_t'(i));
            hit_r = ret && (retire_rd == reg_idx_t'(i));
            hit_s = sqh && (squash_rd == reg_idx_t'(i));
            sum = signed'({2'b00, cnt[i]})
                + signed'({3'b000, hit_i})
                - signed'({3'b000, hit_r})
                - signed'({3'b000, hit_s});
            cnt_nxt[i] = sum[1:0];
            unique case (1'b1)
                (sum > 4'sd3): begin
                    cnt_nxt[i] = SB_MAX;
                    ovf[i] = 1'b1;
                end
                (sum < 4'sd0): begin
                    cnt_nxt[i] = '0;
                    unf[i] = 1'b1;
                end
                default: ;
            endcase
            if (reg_idx_t'(i) == XZR_IDX) begin
                cnt_nxt[i] = '0;
                ovf[i] = 1'b0;
                unf[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt[i] <= '0;
            end
            sb_error <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            sb_error <= sb_error | (|ovf) | (|unf);
        end
    end

    logic rs1_byp;
    logic rs2_byp;

`ifdef WB_BYPASS_EN
    // Falling-edge regfile write makes the last retire visible this cycle
    assign rs1_byp = ret && (retire_rd == rs1) && (cnt[rs1] == 2'd1);
    assign rs2_byp = ret && (retire_rd == rs2) && (cnt[rs2] == 2'd1);
`else
    assign rs1_byp = 1'b0;
    assign rs2_byp = 1'b0;
`endif

    assign rs1_busy = (rs1 != XZR_IDX) && (cnt[rs1] != '0) && !rs1_byp;
    assign rs2_busy = (rs2 != XZR_IDX) && (cnt[rs2] != '0) && !rs2_byp;

endmodule

// File: rtl/writeback_unit.sv
// MEM/WB register, result select and register-file write port, plus
// the pending-write scoreboard (optional WB_BYPASS_EN busy masking).
module writeback_unit
    import wb_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic        mem_reg_write,
    input  logic        mem_to_reg,
    input  logic [63:0] alu_result,
    input  logic [63:0] load_data,
    input  logic        wb_hold,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic        issue_reg_write,
    input  logic        squash_valid,
    input  logic [4:0]  squash_rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic [4:0]  WriteRegister,
    output logic [63:0] WriteData,
    output logic        RegWrite,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        sb_error
);

    mem_wb_t wb_q;
    mem_wb_t wb_d;

    always_comb begin
        wb_d = wb_q;
        if (!wb_hold) begin
            wb_d.valid     = mem_valid;
            wb_d.reg_write = mem_reg_write;
            wb_d.rd        = mem_rd;
            wb_d.data      = mem_to_reg ? load_data : alu_result;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d;
        end
    end

    assign RegWrite = wb_q.valid && wb_q.reg_write
                   && (wb_q.rd != XZR_IDX) && !wb_hold;
    assign WriteRegister = wb_q.rd;
    assign WriteData     = wb_q.data;

    wb_scoreboard u_sb (
        .clk       (clk),
        .reset     (reset),
        .issue_en  (issue_valid && issue_reg_write),
        .issue_rd  (issue_rd),
        .retire_en (RegWrite),
        .retire_rd (WriteRegister),
        .squash_en (squash_valid),
        .squash_rd (squash_rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .sb_error  (sb_error)
    );

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: stimulus queues expected
// responses per cycle, a negedge monitor pops and compares them.
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic        mem_to_reg;
    logic [63:0] alu_result;
    logic [63:0] load_data;
    logic        wb_hold;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_reg_write;
    logic        squash_valid;
    logic [4:0]  squash_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic        RegWrite;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        sb_error;

`ifdef WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    localparam logic [5:0] M_RW  = 6'b000001;
    localparam logic [5:0] M_WR  = 6'b000010;
    localparam logic [5:0] M_WD  = 6'b000100;
    localparam logic [5:0] M_B1  = 6'b001000;
    localparam logic [5:0] M_B2  = 6'b010000;
    localparam logic [5:0] M_ER  = 6'b100000;
    localparam logic [5:0] M_W   = 6'b000111;
    localparam logic [5:0] M_ALL = 6'b111111;

    typedef struct {
        int          cyc;
        string       name;
        logic [5:0]  mask;
        logic        rw;
        logic [4:0]  wr;
        logic [63:0] wd;
        logic        b1;
        logic        b2;
        logic        er;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic drain_to = 1'b0;

    writeback_unit dut (
        .clk             (clk),
        .reset           (reset),
        .mem_valid       (mem_valid),
        .mem_rd          (mem_rd),
        .mem_reg_write   (mem_reg_write),
        .mem_to_reg      (mem_to_reg),
        .alu_result      (alu_result),
        .load_data       (load_data),
        .wb_hold         (wb_hold),
        .issue_valid     (issue_valid),
        .issue_rd        (issue_rd),
        .issue_reg_write (issue_reg_write),
        .squash_valid    (squash_valid),
        .squash_rd       (squash_rd),
        .rs1             (rs1),
        .rs2             (rs2),
        .WriteRegister   (WriteRegister),
        .WriteData       (WriteData),
        .RegWrite        (RegWrite),
        .rs1_busy        (rs1_busy),
        .rs2_busy        (rs2_busy),
        .sb_error        (sb_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string n, input string f,
                         input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s.%s cyc=%0d got=%h want=%h", n, f, cyc, a, e);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            mon_e = q.pop_front();
            if (mon_e.cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL %s missed cyc=%0d want_cyc=%0d",
                         mon_e.name, cyc, mon_e.cyc);
            end else begin
                if (mon_e.mask[0]) check(mon_e.name, "RegWrite", 64'(RegWrite), 64'(mon_e.rw));
                if (mon_e.mask[1]) check(mon_e.name, "WriteRegister", 64'(WriteRegister), 64'(mon_e.wr));
                if (mon_e.mask[2]) check(mon_e.name, "WriteData", WriteData, mon_e.wd);
                if (mon_e.mask[3]) check(mon_e.name, "rs1_busy", 64'(rs1_busy), 64'(mon_e.b1));
                if (mon_e.mask[4]) check(mon_e.name, "rs2_busy", 64'(rs2_busy), 64'(mon_e.b2));
                if (mon_e.mask[5]) check(mon_e.name, "sb_error", 64'(sb_error), 64'(mon_e.er));
            end
        end
        if (drain_to) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d got=nonempty want=empty", q.size());
            q.delete();
            drain_to = 1'b0;
        end
    end

    task automatic push(input string n, input int d, input logic [5:0] m,
                        input logic rw, input logic [4:0] wr,
                        input logic [63:0] wd, input logic b1,
                        input logic b2, input logic er);
        exp_t e;
        e.cyc = cyc + d;
        e.name = n;
        e.mask = m;
        e.rw = rw;
        e.wr = wr;
        e.wd = wd;
        e.b1 = b1;
        e.b2 = b2;
        e.er = er;
        q.push_back(e);
    endtask

    task automatic idle();
        reset = 1'b0;
        mem_valid = 1'b0;
        mem_rd = 5'd0;
        mem_reg_write = 1'b0;
        mem_to_reg = 1'b0;
        alu_result = 64'd0;
        load_data = 64'd0;
        wb_hold = 1'b0;
        issue_valid = 1'b0;
        issue_rd = 5'd0;
        issue_reg_write = 1'b0;
        squash_valid = 1'b0;
        squash_rd = 5'd0;
        rs1 = 5'd0;
        rs2 = 5'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem(input logic [4:0] rd, input logic [63:0] alu);
        mem_valid = 1'b1;
        mem_rd = rd;
        mem_reg_write = 1'b1;
        alu_result = alu;
    endtask

    task automatic issue(input logic [4:0] rd);
        issue_valid = 1'b1;
        issue_rd = rd;
        issue_reg_write = 1'b1;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick();
        // reset dominates MEM capture and issue
        idle(); reset = 1'b1; mem(5'd4, 64'd55); issue(5'd3);
        rs1 = 5'd3; rs2 = 5'd4;
        push("rst", 1, M_ALL, 0, 0, 0, 0, 0, 0);
        tick();
        idle(); reset = 1'b1; wb_hold = 1'b1; mem(5'd4, 64'd55);
        issue(5'd3); rs1 = 5'd3; rs2 = 5'd4;
        push("rst_hold", 1, M_ALL, 0, 0, 0, 0, 0, 0);
        tick();
        idle(); issue(5'd5); rs1 = 5'd5;
        tick();
        idle(); mem(5'd5, 64'd123); mem_to_reg = 1'b1;
        load_data = 64'hDEAD_BEEF_0000_0001; rs1 = 5'd5;
        push("iss5", 0, M_B1 | M_ER, 0, 0, 0, 1, 0, 0);
        push("load", 1, M_W | M_B1 | M_ER, 1, 5,
             64'hDEAD_BEEF_0000_0001, !BYP, 0, 0);
        tick();
        idle(); rs1 = 5'd5;
        push("ret5", 1, M_RW | M_B1 | M_ER, 0, 0, 0, 0, 0, 0);
        tick();
        idle(); mem(5'd31, 64'd7); issue(5'd31); rs1 = 5'd31; rs2 = 5'd5;
        push("x31", 1, M_W | M_B1 | M_B2 | M_ER, 0, 31, 64'd7, 0, 0, 0);
        tick();
        idle(); rs1 = 5'd31;
        push("x31_busy", 1, M_B1 | M_ER, 0, 0, 0, 0, 0, 0);
        tick();
        idle(); issue(5'd3); rs1 = 5'd3;
        tick();
        idle(); issue(5'd3); rs1 = 5'd3;
        push("iss3a", 0, M_B1, 0, 0, 0, 1, 0, 0);
        tick();
        idle(); mem(5'd3, 64'd9); rs1 = 5'd3;
        push("iss3b", 0, M_RW | M_B1, 0, 0, 0, 1, 0, 0);
        tick();
        idle(); rs1 = 5'd3;
        push("ret3", 0, M_W | M_B1 | M_ER, 1, 3, 64'd9, 1, 0, 0);
        tick();
        idle(); squash_valid = 1'b1; squash_rd = 5'd3; rs1 = 5'd3;
        push("ret3_cnt1", 0, M_RW | M_B1, 0, 0, 0, 1, 0, 0);
        tick();
        idle(); rs1 = 5'd3;
        push("squash3", 0, M_B1 | M_ER, 0, 0, 0, 0, 0, 0);
        tick();
        idle(); issue(5'd9); rs1 = 5'd9;
        tick();
        idle(); mem(5'd9, 64'h99); rs1 = 5'd9;
        push("iss9", 0, M_B1, 0, 0, 0, 1, 0, 0);
        tick();
        idle(); issue(5'd9); rs1 = 5'd9;
        push("ir9_wb", 0, M_W, 1, 9, 64'h99, 0, 0, 0);
        tick();
        idle(); mem(5'd9, 64'h9a); rs1 = 5'd9;
        push("ir9_keep", 0, M_RW | M_B1 | M_ER, 0, 0, 0, 1, 0, 0);
        tick();
        idle(); rs1 = 5'd9;
        push("byp9", 0, M_W | M_B1, 1, 9, 64'h9a, !BYP, 0, 0);
        tick();
        idle(); rs1 = 5'd9;
        push("clr9", 0, M_B1 | M_ER, 0, 0, 0, 0, 0, 0);
        tick();
        idle(); issue(5'd6); mem(5'd6, 64'h66); rs2 = 5'd6;
        tick();
        idle(); wb_hold = 1'b1; mem(5'd7, 64'h77); rs2 = 5'd6;
        push("hold1", 0, M_W | M_B2, 0, 6, 64'h66, 0, 1, 0);
        tick();
        idle(); wb_hold = 1'b1; mem(5'd8, 64'h88); mem_to_reg = 1'b1;
        load_data = 64'h8888; rs2 = 5'd6;
        push("hold2", 0, M_W | M_B2, 0, 6, 64'h66, 0, 1, 0);
        tick();
        idle(); wb_hold = 1'b1; mem(5'd10, 64'haa); rs2 = 5'd6;
        push("hold3", 0, M_W | M_B2, 0, 6, 64'h66, 0, 1, 0);
        tick();
        idle(); rs2 = 5'd6;
        push("unhold", 0, M_W | M_B2 | M_ER, 1, 6, 64'h66, 0, !BYP, 0);
        tick();
        idle(); rs2 = 5'd6;
        push("unhold_clr", 0, M_RW | M_B2 | M_ER, 0, 0, 0, 0, 0, 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            idle(); issue(5'd2); rs1 = 5'd2;
            if (k > 0) push($sformatf("sat%0d", k), 0, M_B1 | M_ER,
                            0, 0, 0, 1, 0, 0);
            tick();
        end
        idle(); mem(5'd14, 64'h1414); rs1 = 5'd2;
        push("sat_err", 0, M_B1 | M_ER, 0, 0, 0, 1, 0, 1);
        tick();
        idle(); wb_hold = 1'b1; rs1 = 5'd2; rs2 = 5'd14;
        push("hold_err", 0, M_W | M_B1 | M_B2 | M_ER,
             0, 14, 64'h1414, 1, 0, 1);
        tick();
        idle(); reset = 1'b1; wb_hold = 1'b1; issue(5'd2);
        mem(5'd15, 64'h15); rs1 = 5'd2; rs2 = 5'd14;
        push("reset_all", 1, M_ALL, 0, 0, 0, 0, 0, 0);
        tick();
        idle(); rs1 = 5'd2; rs2 = 5'd14;
        push("post_rst", 1, M_ALL, 0, 0, 0, 0, 0, 0);
        tick();
        idle();
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) drain_to = 1'b1;
        @(negedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Write-side driver for the 64-bit, 32-entry register file of the pipelined CPU: holds the MEM/WB pipeline register, selects the result, and drives the register file's write port (WriteRegister, WriteData, RegWrite). Also keeps a per-register pending-write scoreboard for the decode-stage hazard check, so decode can stall on destinations still in flight. Sits between the MEM stage and the register file's write port; decode queries the scoreboard.

## Interface
- No parameters; widths fixed: 64-bit data, 5-bit register index, X31 hard-wired zero.
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  synchronous, active-high.
- mem_valid  input  1  MEM stage holds a valid instruction this cycle.
- mem_rd  input  5  destination register.
- mem_reg_write  input  1  instruction writes a register.
- mem_to_reg  input  1  1 = load_data, 0 = alu_result.
- alu_result  input  64  ALU result from MEM.
- load_data  input  64  data-memory read data.
- wb_hold  input  1  freeze MEM/WB register; no retire this cycle.
- issue_valid  input  1  instruction enters EX this cycle (ID/EX capture).
- issue_rd  input  5  its destination.
- issue_reg_write  input  1  it writes a register.
- squash_valid  input  1  one issued instruction is killed before WB.
- squash_rd  input  5  its destination.
- rs1, rs2  input  5 each  decode source registers to check.
- WriteRegister  output  5  to register file.
- WriteData  output  64  to register file.
- RegWrite  output  1  to register file.
- rs1_busy, rs2_busy  output  1 each  pending write to rs1/rs2.
- sb_error  output  1  sticky: counter overflow or underflow.

## Operation
- MEM/WB register: when !wb_hold, captures mem_valid, mem_rd, mem_reg_write, and the mem_to_reg-selected 64-bit result. When wb_hold, all fields hold.
- Write port: RegWrite = wb_valid & wb_reg_write & (wb_rd != 31) & !wb_hold. WriteRegister = wb_rd. WriteData = wb_data.
- Retire event = RegWrite asserted this cycle.
- Scoreboard: one 2-bit counter per register 0..30; register 31 is never tracked and never busy.
  - issue event (issue_valid & issue_reg_write & issue_rd != 31): +1 on that register.
  - retire event: −1 on WriteRegister.
  - squash event (squash_valid, squash_rd != 31): −1 on that register.
  - Net change per counter = sum of the events in that cycle. Issue + retire on the same register means no change. Up to 3 events may hit one register.
- rsN_busy = (counter[rsN] != 0) when rsN != 31, else 0. Purely combinational from counters and inputs.
- Overflow (result > 3) or underflow (result < 0): the counter saturates at 3 or 0, and sb_error sets. sb_error clears only on reset.

## Timing
- Latency: MEM inputs captured at edge N; RegWrite/WriteData valid during cycle N+1. The register file captures on the falling edge, so a decode read in cycle N+1 sees the new value.
- Counters update at the rising edge after the event. busy reflects the updated count from the next cycle.
- Reset (any cycle, including mid-hold): wb_valid=0, wb_reg_write=0, wb_rd=0, wb_data=0, all counters 0, sb_error=0.
  - Resulting outputs: RegWrite=0, WriteRegister=0, WriteData=0, busy=0.
  - reset dominates all events in that cycle.
- wb_hold and a squash in the same cycle: the squash is still applied; only the retire is suppressed.

## Configuration
- WB_BYPASS_EN defined: rsN_busy is additionally masked when a retire event to rsN happens this cycle and the counter equals 1. Rationale: the falling-edge register file write is visible to the same-cycle decode read, saving one stall cycle.
- WB_BYPASS_EN undefined: busy = counter != 0, with no same-cycle masking.

## Structure
- Package wb_pkg holds:
  - typedefs reg_idx_t (5 bits), data_t (64 bits), sb_cnt_t (2 bits)
  - constants XZR_IDX = 31, NUM_REGS = 32, SB_MAX = 3
- One sub-module, wb_scoreboard, contains the counter array, event summation, saturation, sb_error, and the busy lookup.
- writeback_unit instantiates wb_scoreboard and contains the MEM/WB register and the result mux.

## Test plan
- Load retire: reset, then mem_valid=1, mem_rd=5, mem_reg_write=1, mem_to_reg=1, load_data=64'hDEAD_BEEF_0000_0001. Next cycle: RegWrite=1, WriteRegister=5, WriteData=64'hDEAD_BEEF_0000_0001.
- X31 write: mem_rd=31, mem_reg_write=1, alu_result=7. Next cycle: RegWrite=0. Also issue to rd=31: rs1=31 never busy.
- Scoreboard sequence on rd=3, all with rs1=3:
  - issue: busy=1 the next cycle.
  - a second issue: counter=2.
  - retire: counter=1, busy=1.
  - squash: busy=0.
- Simultaneous issue and retire to rd=9 with counter=1: counter stays 1, busy stays 1. With WB_BYPASS_EN, busy=0 during a retire cycle that starts from counter=1 and has no issue.
- Hold plus saturation:
  - wb_hold=1 for 3 cycles while MEM inputs change: RegWrite=0 and WriteData unchanged.
  - 4 issues to rd=2 with no retire: counter=3 and sb_error=1.
  - reset: all outputs 0.
